// File: rtl/vga_scanout_if.sv
// Display-side bundle between vga_scanout, the colour buffer read port and the DAC pins.
interface vga_scanout_if;
  logic [9:0]  horizCount;
  logic [9:0]  vertCount;
  logic [7:0]  cellAddr;
  logic [11:0] cellColor;
  logic        hSync;
  logic        vSync;
  logic [3:0]  vgaRed;
  logic [3:0]  vgaGreen;
  logic [3:0]  vgaBlue;
  logic        frameStart;

  modport master (
    output horizCount, vertCount, cellAddr, hSync, vSync,
    output vgaRed, vgaGreen, vgaBlue, frameStart,
    input  cellColor
  );

  modport slave (
    input  horizCount, vertCount, cellAddr, hSync, vSync,
    input  vgaRed, vgaGreen, vgaBlue, frameStart,
    output cellColor
  );
endinterface

// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout: raster counters, cell-buffer addressing and a 2-stage pin pipeline.
// Optional macro PIXEL_DIV_EN divides clk by 4 to form the pixel tick.
module vga_scanout #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned BSIZE     = 40
) (
  input logic           clk,
  input logic           reset,
  vga_scanout_if.master bus
);

  localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] HLast   = 10'(HTotal - 1);
  localparam logic [9:0] VLast   = 10'(VTotal - 1);
  localparam logic [9:0] HVis    = 10'(H_VISIBLE);
  localparam logic [9:0] VVis    = 10'(V_VISIBLE);
  localparam logic [9:0] HsFirst = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HsLast  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VsFirst = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VsLast  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [5:0] SubLast = 6'(BSIZE - 1);

  logic tick;

`ifdef PIXEL_DIV_EN
  logic [1:0] div_q, div_d;

  always_comb div_d = div_q + 2'd1;

  always_ff @(posedge clk) begin
    if (reset) div_q <= 2'd0;
    else       div_q <= div_d;
  end

  assign tick = (div_q == 2'd3);
`else
  assign tick = 1'b1;
`endif

  // Stage 0: raster position and cell tracking
  logic [9:0]  h_q, h_d, v_q, v_d;
  logic [5:0]  hsub_q, hsub_d, vsub_q, vsub_d;
  logic [3:0]  col_q, col_d, row_q, row_d;
  // Stage 1 / stage 2 pipeline
  logic        vis_d1_q, vis_d1_d, hs_d1_q, hs_d1_d, vs_d1_q, vs_d1_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d;
  logic [11:0] rgb_q, rgb_d;
  logic        frame_start_q, frame_start_d;

  logic h_last, v_last, visible, hs_raw, vs_raw;

  always_comb begin
    h_last  = (h_q == HLast);
    v_last  = (v_q == VLast);
    visible = (h_q < HVis) && (v_q < VVis);
    hs_raw  = !((h_q >= HsFirst) && (h_q <= HsLast));
    vs_raw  = !((v_q >= VsFirst) && (v_q <= VsLast));

    h_d           = h_q;
    v_d           = v_q;
    hsub_d        = hsub_q;
    vsub_d        = vsub_q;
    col_d         = col_q;
    row_d         = row_q;
    vis_d1_d      = vis_d1_q;
    hs_d1_d       = hs_d1_q;
    vs_d1_d       = vs_d1_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    rgb_d         = rgb_q;
    frame_start_d = frame_start_q;

    if (tick) begin
      if (h_last) begin
        h_d    = 10'd0;
        hsub_d = 6'd0;
        col_d  = 4'd0;
        if (v_last) begin
          v_d    = 10'd0;
          vsub_d = 6'd0;
          row_d  = 4'd0;
        end else begin
          v_d = v_q + 10'd1;
          if (vsub_q == SubLast) begin
            vsub_d = 6'd0;
            row_d  = row_q + 4'd1;
          end else begin
            vsub_d = vsub_q + 6'd1;
          end
        end
      end else begin
        h_d = h_q + 10'd1;
        // col may wrap past 15 in horizontal blanking; cellAddr is gated by visible there.
        if (hsub_q == SubLast) begin
          hsub_d = 6'd0;
          col_d  = col_q + 4'd1;
        end else begin
          hsub_d = hsub_q + 6'd1;
        end
      end

      vis_d1_d      = visible;
      hs_d1_d       = hs_raw;
      vs_d1_d       = vs_raw;
      hsync_d       = hs_d1_q;
      vsync_d       = vs_d1_q;
      rgb_d         = vis_d1_q ? bus.cellColor : 12'h000;
      frame_start_d = h_last && v_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q           <= 10'd0;
      v_q           <= 10'd0;
      hsub_q        <= 6'd0;
      vsub_q        <= 6'd0;
      col_q         <= 4'd0;
      row_q         <= 4'd0;
      vis_d1_q      <= 1'b0;
      hs_d1_q       <= 1'b1;
      vs_d1_q       <= 1'b1;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      rgb_q         <= 12'h000;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hsub_q        <= hsub_d;
      vsub_q        <= vsub_d;
      col_q         <= col_d;
      row_q         <= row_d;
      vis_d1_q      <= vis_d1_d;
      hs_d1_q       <= hs_d1_d;
      vs_d1_q       <= vs_d1_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.horizCount = h_q;
  assign bus.vertCount  = v_q;
  assign bus.cellAddr   = visible ? {row_q, col_q} : 8'd0;
  assign bus.hSync      = hsync_q;
  assign bus.vSync      = vsync_q;
  assign bus.vgaRed     = rgb_q[11:8];
  assign bus.vgaGreen   = rgb_q[7:4];
  assign bus.vgaBlue    = rgb_q[3:0];
  assign bus.frameStart = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a full-size instance for line-level timing and a scaled instance
// (4-pixel cells, 80x55 raster) for frame-level behaviour, both checked against a pin scoreboard.
module tb_vga_scanout;

`ifdef PIXEL_DIV_EN
  localparam int Tpc      = 4;
  localparam int RunTicks = 4500;
`else
  localparam int Tpc      = 1;
  localparam int RunTicks = 32130;
`endif

  typedef struct packed {
    int hv; int hf; int hs; int hb; int vv; int vf; int vs; int vb; int bs;
  } geo_t;

  localparam geo_t G0 = '{hv: 640, hf: 16, hs: 96, hb: 48, vv: 480, vf: 10, vs: 2, vb: 33,
                          bs: 40};
  localparam geo_t G1 = '{hv: 64, hf: 4, hs: 8, hb: 4, vv: 48, vf: 2, vs: 2, vb: 3, bs: 4};

  logic clk;
  logic reset;

  vga_scanout_if bus0 ();
  vga_scanout_if bus1 ();

  vga_scanout u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  vga_scanout #(
    .H_VISIBLE (64),
    .H_FRONT   (4),
    .H_SYNC    (8),
    .H_BACK    (4),
    .V_VISIBLE (48),
    .V_FRONT   (2),
    .V_SYNC    (2),
    .V_BACK    (3),
    .BSIZE     (4)
  ) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous colour buffers: one bright-red cell on the full-size instance, all white on the
  // scaled one.
  always @(posedge clk) begin
    bus0.cellColor <= (bus0.cellAddr == 8'd18) ? 12'hF00 : 12'h000;
    bus1.cellColor <= 12'hFFF;
  end

  int checks = 0;
  int errors = 0;
  int n, clk_cnt, first799, fs_clks, vs_low, vs_first;
  logic [13:0] q0[$];
  logic [13:0] q1[$];

  function automatic int htot(geo_t g);
    return g.hv + g.hf + g.hs + g.hb;
  endfunction

  function automatic int vtot(geo_t g);
    return g.vv + g.vf + g.vs + g.vb;
  endfunction

  function automatic logic [7:0] exp_addr(int h, int v, geo_t g);
    if (h < g.hv && v < g.vv) return 8'((v / g.bs) * 16 + h / g.bs);
    return 8'd0;
  endfunction

  // {hSync, vSync, rgb} expected on the pins two ticks after the raster is at (h, v)
  function automatic logic [13:0] exp_pins(int h, int v, geo_t g, int mode);
    logic        vis, hs, vs;
    logic [11:0] col;
    vis = (h < g.hv) && (v < g.vv);
    hs  = !((h >= g.hv + g.hf) && (h < g.hv + g.hf + g.hs));
    vs  = !((v >= g.vv + g.vf) && (v < g.vv + g.vf + g.vs));
    if (mode == 0) col = (exp_addr(h, v, g) == 8'd18) ? 12'hF00 : 12'h000;
    else           col = 12'hFFF;
    return {hs, vs, vis ? col : 12'h000};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    for (int i = 0; i < Tpc; i++) begin
      @(posedge clk);
      clk_cnt++;
      @(negedge clk);
      if (bus0.horizCount == 10'd799 && first799 < 0) first799 = clk_cnt;
      if (n < 4500 && bus1.frameStart === 1'b1) fs_clks++;
    end
    n++;
  endtask

  task automatic init_model();
    n        = 0;
    clk_cnt  = 0;
    first799 = -1;
    fs_clks  = 0;
    vs_low   = 0;
    vs_first = -1;
    q0.delete();
    q1.delete();
    // Pipeline registers come out of reset blank with sync inactive.
    for (int i = 0; i < 2; i++) begin
      q0.push_back(14'h3000);
      q1.push_back(14'h3000);
    end
  endtask

  task automatic hold_reset(input int ticks);
    reset = 1'b1;
    repeat (ticks * Tpc) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    init_model();
  endtask

  task automatic check_now();
    int h0, v0, h1, v1;
    logic [13:0] e;
    h0 = n % htot(G0);
    v0 = (n / htot(G0)) % vtot(G0);
    h1 = n % htot(G1);
    v1 = (n / htot(G1)) % vtot(G1);

    chk("h0", 32'(bus0.horizCount), 32'(h0));
    chk("v0", 32'(bus0.vertCount), 32'(v0));
    chk("addr0", 32'(bus0.cellAddr), 32'(exp_addr(h0, v0, G0)));
    chk("fs0", 32'(bus0.frameStart), 32'(h0 == 0 && v0 == 0 && n > 0));
    q0.push_back(exp_pins(h0, v0, G0, 0));
    e = q0.pop_front();
    chk("pins0", 32'({bus0.hSync, bus0.vSync, bus0.vgaRed, bus0.vgaGreen, bus0.vgaBlue}),
        32'(e));

    chk("h1", 32'(bus1.horizCount), 32'(h1));
    chk("v1", 32'(bus1.vertCount), 32'(v1));
    chk("addr1", 32'(bus1.cellAddr), 32'(exp_addr(h1, v1, G1)));
    chk("fs1", 32'(bus1.frameStart), 32'(h1 == 0 && v1 == 0 && n > 0));
    q1.push_back(exp_pins(h1, v1, G1, 1));
    e = q1.pop_front();
    chk("pins1", 32'({bus1.hSync, bus1.vSync, bus1.vgaRed, bus1.vgaGreen, bus1.vgaBlue}),
        32'(e));

    if (n <= 4400 && bus1.vSync === 1'b0) begin
      vs_low++;
      if (vs_first < 0) vs_first = n;
    end
  endtask

  initial begin
    reset = 1'b1;
    hold_reset(3);
    check_now();
    for (int k = 0; k < 300; k++) begin
      step();
      check_now();
    end

    // Mid-line reset at horizCount = 300
    hold_reset(3);
    chk("rst_h", 32'(bus0.horizCount), 32'd0);
    chk("rst_v", 32'(bus0.vertCount), 32'd0);
    chk("rst_hsync", 32'(bus0.hSync), 32'd1);
    chk("rst_vsync", 32'(bus0.vSync), 32'd1);
    chk("rst_rgb", 32'({bus0.vgaRed, bus0.vgaGreen, bus0.vgaBlue}), 32'd0);
    chk("rst_addr", 32'(bus0.cellAddr), 32'd0);
    chk("rst_fs", 32'(bus0.frameStart), 32'd0);
    check_now();

    for (int k = 0; k < RunTicks; k++) begin
      step();
      check_now();
      if (n == 657)   chk("hsync_before_fall", 32'(bus0.hSync), 32'd1);
      if (n == 658)   chk("hsync_fall", 32'(bus0.hSync), 32'd0);
      if (n == 753)   chk("hsync_last_low", 32'(bus0.hSync), 32'd0);
      if (n == 754)   chk("hsync_rise", 32'(bus0.hSync), 32'd1);
      if (n == 3823)  chk("addr_last_cell", 32'(bus1.cellAddr), 32'd191);
      if (n == 3824)  chk("addr_past_visible", 32'(bus1.cellAddr), 32'd0);
      if (n == 4400)  chk("wrap_fs", 32'(bus1.frameStart), 32'd1);
      if (n == 4401)  chk("wrap_fs_drop", 32'(bus1.frameStart), 32'd0);
      if (n == 32080) chk("addr_18", 32'(bus0.cellAddr), 32'd18);
      if (n == 32081) chk("rgb_before_cell", 32'({bus0.vgaRed, bus0.vgaGreen, bus0.vgaBlue}),
                          32'd0);
      if (n == 32082) chk("red_first", 32'(bus0.vgaRed), 32'd15);
      if (n == 32121) chk("red_last", 32'(bus0.vgaRed), 32'd15);
      if (n == 32122) chk("rgb_after_cell", 32'({bus0.vgaRed, bus0.vgaGreen, bus0.vgaBlue}),
                          32'd0);
    end

    chk("vsync_low_ticks", 32'(vs_low), 32'd160);
    chk("vsync_first_tick", 32'(vs_first), 32'd4002);
    chk("framestart_clks", 32'(fs_clks), 32'(Tpc));
    chk("h799_clk", 32'(first799), 32'(799 * Tpc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Display-side reader of the 16x12 cell colour buffer (40x40-pixel cells, 192 entries, 12-bit RGB 4:4:4) written by the graphics generator.
- Generates 640x480@60 VGA timing and the horizCount/vertCount raster position that the graphics generator consumes.
- Reads one cell colour per pixel tick through a synchronous read port and drives hSync, vSync and 4-bit R/G/B to the DAC pins, with sync and colour aligned.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hSync pulse width
- H_BACK, 48, horizontal back porch (line total 800)
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vSync pulse width
- V_BACK, 33, vertical back porch (frame total 525)
- BSIZE, 40, cell edge in pixels

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- horizCount  out  10  current pixel column, 0..799
- vertCount  out  10  current line, 0..524
- cellAddr  out  8  buffer read address = row*16 + col
- cellColor  in  12  buffer read data {R,G,B}; valid one tick after cellAddr
- hSync  out  1  horizontal sync, active low
- vSync  out  1  vertical sync, active low
- vgaRed  out  4  red to DAC
- vgaGreen  out  4  green to DAC
- vgaBlue  out  4  blue to DAC
- frameStart  out  1  one-tick pulse when counters wrap to (0,0)

Behaviour:
- Tick: every clk when PIXEL_DIV_EN is undefined; otherwise see Optional Feature. All state advances only on ticks.
- Reset values: horizCount=0, vertCount=0, cellAddr=0, hSync=1, vSync=1, RGB=0, frameStart=0. All pipeline registers are cleared to blank with sync inactive. Reset at any point restarts the frame at (0,0) on the next tick.
- Counters:
  - horizCount increments per tick and wraps 799->0.
  - vertCount increments when horizCount wraps, and wraps 524->0.
  - frameStart=1 for exactly the tick where both counters are 0, except the first tick after reset.
- Cell tracking: no dividers. hSub (0..39) and col (0..15) advance with horizCount; vSub/row (0..11) advance with vertCount. All clear when the corresponding counter wraps.
- cellAddr = {row[3:0], col[3:0]}, combinational from stage-0 state. It is 0 when the position is outside the visible area.
- Visible: horizCount<H_VISIBLE and vertCount<V_VISIBLE.
- Raw sync:
  - hSync low for horizCount in [656, 751].
  - vSync low for vertCount in [490, 491].
- Pipeline (latency 2 ticks from counters to pins):
  - Stage 1 registers visible, raw hSync and raw vSync; cellColor arrives in this stage.
  - Stage 2 registers outputs: RGB = visible_d1 ? cellColor : 0; hSync and vSync come from stage 1.
  - Pins therefore show position (horizCount-2) with matching sync, wrap-aware.
- Blanking: RGB is forced to 0 whenever the delayed visible flag is 0, whatever the value of cellColor.
- Counters never exceed their totals. Sync outputs are never X after reset.

Optional Feature:
- Macro: PIXEL_DIV_EN.
- Defined: internal 2-bit divider; tick asserts on every 4th clk (100 MHz -> 25 MHz). Counters, pipeline and frameStart advance only on ticks. frameStart is high for one full tick (4 clk). The divider resets to 0, so the first tick occurs on the 4th clk after reset release.
- Undefined: every clk is a tick and no divider logic exists.

Test Plan:
- Reset: hold reset 3 ticks mid-line at horizCount=300 -> next tick shows horizCount=0, vertCount=0, hSync=vSync=1, RGB=0, cellAddr=0.
- Addressing: at horizCount=80, vertCount=40 -> cellAddr=18. At horizCount=639, vertCount=479 -> cellAddr=191. At horizCount=640 -> cellAddr=0.
- Colour alignment: buffer model returns 12'hF00 for addr 18, 0 elsewhere -> vgaRed=15, vgaGreen=0, vgaBlue=0 exactly on ticks where horizCount is 82..121 at vertCount 40; RGB=0 on the adjacent ticks.
- Sync timing: hSync falls on the tick where horizCount=658 and rises at horizCount=754 (96 ticks low). vSync is low for exactly 1600 ticks, starting at vertCount=490, horizCount=2.
- Blanking/wrap: buffer returns 12'hFFF for all addresses -> RGB=0 from horizCount 642..799 and 0..1 of the next line. At horizCount=799, vertCount=524 the next tick gives (0,0) with frameStart=1 for exactly one tick. Frame length is 420000 ticks.
- PIXEL_DIV_EN: horizCount increments once per 4 clk and reaches 799 after 3196 clk from reset release (first tick on clk 4). frameStart stays high for 4 consecutive clk.
